// File: rtl/arb_pkg.sv
// Shared definitions for the 4-requester grant arbiter and its downstream burst forwarder.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SRC_W   = 2;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_GNT0 = 3'd1,
    ARB_GNT1 = 3'd2,
    ARB_GNT2 = 3'd3,
    ARB_GNT3 = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    FWD_IDLE   = 2'd0,
    FWD_ACTIVE = 2'd1,
    FWD_DRAIN  = 2'd2
  } fwd_state_e;

  function automatic logic [2:0] gnt_count(input logic [NUM_REQ-1:0] g);
    gnt_count = 3'(g[0]) + 3'(g[1]) + 3'(g[2]) + 3'(g[3]);
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic logic [SRC_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] g);
    onehot_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g[i]) onehot_idx = SRC_W'(i);
    end
  endfunction

endpackage

// File: rtl/burst_out_reg.sv
// Single output register toward the sink: holds {data, src, last} stable until taken.
module burst_out_reg
  import arb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             mark_last,
  input  logic [DW-1:0]    in_data,
  input  logic [SRC_W-1:0] in_src,
  input  logic             in_last,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic [SRC_W-1:0] out_src,
  output logic             out_last,
  input  logic             out_ready,
  output logic             space
);

  logic [DW+SRC_W:0] beat;

  assign space = !out_valid || out_ready;
  assign {out_data, out_src, out_last} = beat;

  // load is only raised when space is set, so a held beat is never overwritten.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      beat      <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      beat      <= {in_data, in_src, in_last};
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (mark_last && out_valid && !out_ready) beat[0] <= 1'b1;
    end
  end

endmodule

// File: rtl/gnt_burst_forwarder.sv
// Forwards the granted requester's burst to one shared sink and reports completion/protocol faults.
module gnt_burst_forwarder
  import arb_pkg::*;
#(
  parameter int DW        = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             gnt_0,
  input  logic             gnt_1,
  input  logic             gnt_2,
  input  logic             gnt_3,
  input  logic             valid_0,
  input  logic             valid_1,
  input  logic             valid_2,
  input  logic             valid_3,
  input  logic [DW-1:0]    data_0,
  input  logic [DW-1:0]    data_1,
  input  logic [DW-1:0]    data_2,
  input  logic [DW-1:0]    data_3,
  input  logic             last_0,
  input  logic             last_1,
  input  logic             last_2,
  input  logic             last_3,
  output logic             ready_0,
  output logic             ready_1,
  output logic             ready_2,
  output logic             ready_3,
  output logic             done_0,
  output logic             done_1,
  output logic             done_2,
  output logic             done_3,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic [SRC_W-1:0] out_src,
  output logic             out_last,
  input  logic             out_ready,
  output logic             err_multi,
  output logic             err_abort,
  output fwd_state_e       state
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  // Handshakes: a beat moves when valid and ready are both high at a rising edge;
  // ready_N never depends on anything but registered state, gnt/valid of N and out_ready.

  logic [NUM_REQ-1:0] gnt, valid, last;
  logic [DW-1:0]      data_v [NUM_REQ];

  assign gnt   = {gnt_3, gnt_2, gnt_1, gnt_0};
  assign valid = {valid_3, valid_2, valid_1, valid_0};
  assign last  = {last_3, last_2, last_1, last_0};
  assign data_v[0] = data_0;
  assign data_v[1] = data_1;
  assign data_v[2] = data_2;
  assign data_v[3] = data_3;

  fwd_state_e         state_n;
  logic [SRC_W-1:0]   src, src_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               set_multi, set_abort;
  logic               ld, ld_last, mark, space;
  logic [DW-1:0]      ld_data;
  logic [NUM_REQ-1:0] ready_v, done_v;
  logic               gnt_s, valid_s, last_s;

  assign gnt_s   = gnt[src];
  assign valid_s = valid[src];
  assign last_s  = last[src];

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FWD_IDLE;
      src       <= '0;
      cnt       <= '0;
      err_multi <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      state <= state_n;
      src   <= src_n;
      cnt   <= cnt_n;
      if (set_multi) err_multi <= 1'b1;
      if (set_abort) err_abort <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    src_n     = src;
    cnt_n     = cnt;
    set_multi = 1'b0;
    set_abort = 1'b0;
    ld        = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;
    mark      = 1'b0;
    ready_v   = '0;
    done_v    = '0;
    case (state)
      FWD_IDLE: begin
        if (gnt_count(gnt) == 3'd1) begin
          src_n   = onehot_idx(gnt);
          cnt_n   = '0;
          state_n = FWD_ACTIVE;
        end else if (gnt_count(gnt) > 3'd1) begin
          set_multi = 1'b1;
        end
      end
      FWD_ACTIVE: begin
        if (!gnt_s) begin
          // Grant lost mid-burst: terminate the sink burst with a last beat.
          set_abort   = 1'b1;
          done_v[src] = 1'b1;
          state_n     = FWD_DRAIN;
          if (space) begin
            ld      = 1'b1;
            ld_last = 1'b1;
          end else begin
            mark = 1'b1;
          end
        end else if (valid_s && space) begin
          ready_v[src] = 1'b1;
          ld           = 1'b1;
          ld_data      = data_v[src];
          ld_last      = last_s || (cnt == CNT_W'(MAX_BEATS - 1));
          if (cnt != CNT_W'(MAX_BEATS)) cnt_n = cnt + 1'b1;
          if (ld_last) begin
            done_v[src] = 1'b1;
            state_n     = FWD_DRAIN;
          end
        end
      end
      FWD_DRAIN: begin
        if (space && !gnt_s) state_n = FWD_IDLE;
      end
      default: state_n = FWD_IDLE;
    endcase
    if (reset) begin
      ready_v = '0;
      done_v  = '0;
      ld      = 1'b0;
      mark    = 1'b0;
    end
  end

  assign {ready_3, ready_2, ready_1, ready_0} = ready_v;
  assign {done_3, done_2, done_1, done_0}     = done_v;

  burst_out_reg #(.DW(DW)) u_out (
    .clock     (clock),
    .reset     (reset),
    .load      (ld),
    .mark_last (mark),
    .in_data   (ld_data),
    .in_src    (src),
    .in_last   (ld_last),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_ready (out_ready),
    .space     (space)
  );

endmodule

// File: tb/tb_gnt_burst_forwarder.sv
// Bench for gnt_burst_forwarder: directed scenarios with literal checks plus randomized bursts against a reference model.
module tb_gnt_burst_forwarder;
  import arb_pkg::*;

  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [3:0]       gnt, valid, last, ready, done;
  logic [DW-1:0]    data [4];
  logic             out_valid, out_last, out_ready, err_multi, err_abort;
  logic [DW-1:0]    out_data;
  logic [1:0]       out_src;
  fwd_state_e       dut_state;

  int n_cmp = 0;
  int n_err = 0;

  gnt_burst_forwarder #(.DW(DW), .MAX_BEATS(MAXB)) dut (
    .clock(clock), .reset(reset),
    .gnt_0(gnt[0]), .gnt_1(gnt[1]), .gnt_2(gnt[2]), .gnt_3(gnt[3]),
    .valid_0(valid[0]), .valid_1(valid[1]), .valid_2(valid[2]), .valid_3(valid[3]),
    .data_0(data[0]), .data_1(data[1]), .data_2(data[2]), .data_3(data[3]),
    .last_0(last[0]), .last_1(last[1]), .last_2(last[2]), .last_3(last[3]),
    .ready_0(ready[0]), .ready_1(ready[1]), .ready_2(ready[2]), .ready_3(ready[3]),
    .done_0(done[0]), .done_1(done[1]), .done_2(done[2]), .done_3(done[3]),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_last(out_last),
    .out_ready(out_ready), .err_multi(err_multi), .err_abort(err_abort), .state(dut_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Model: burst phase (0 idle, 1 streaming, 2 waiting for sink/grant release),
  // the beat sitting in front of the sink, beats sent this burst, sticky errors.
  int            m_phase, m_src, m_sent;
  logic          m_ov, m_ol, m_em, m_ea;
  logic [DW-1:0] m_od;
  logic [1:0]    m_os;
  bit            armed = 0;
  logic [DW+2:0] exp_q [$];

  task automatic model_emit(input logic [DW-1:0] d, input logic l);
    m_ov = 1'b1;
    m_od = d;
    m_os = 2'(m_src);
    m_ol = l;
    exp_q.push_back({d, 2'(m_src), l});
  endtask

  always @(negedge clock) begin
    logic [3:0]    e_ready, e_done;
    logic          sp, bl;
    logic [DW+2:0] b;
    int            ng;
    if (reset) begin
      armed = 1;
      chk("ready_in_reset", 32'(ready), 32'd0);
      chk("done_in_reset", 32'(done), 32'd0);
      m_phase = 0; m_src = 0; m_sent = 0;
      m_ov = 0; m_ol = 0; m_od = '0; m_os = '0; m_em = 0; m_ea = 0;
      exp_q.delete();
    end else if (armed) begin
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("out_src", 32'(out_src), 32'(m_os));
        chk("out_last", 32'(out_last), 32'(m_ol));
      end
      chk("err_multi", 32'(err_multi), 32'(m_em));
      chk("err_abort", 32'(err_abort), 32'(m_ea));
      chk("state", 32'(dut_state),
          m_phase == 0 ? 32'(FWD_IDLE) : (m_phase == 1 ? 32'(FWD_ACTIVE) : 32'(FWD_DRAIN)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sink_beat: got unexpected beat %0h expected none", out_data);
        end else begin
          b = exp_q.pop_front();
          chk("sink_beat", 32'({out_data, out_src, out_last}), 32'(b));
        end
      end
      sp = !m_ov || out_ready;
      e_ready = '0;
      e_done  = '0;
      if (m_ov && out_ready) m_ov = 1'b0;
      case (m_phase)
        0: begin
          ng = $countones(gnt);
          if (ng == 1) begin
            for (int k = 0; k < 4; k++) if (gnt[k]) m_src = k;
            m_sent  = 0;
            m_phase = 1;
          end else if (ng > 1) begin
            m_em = 1'b1;
          end
        end
        1: begin
          if (!gnt[m_src]) begin
            m_ea = 1'b1;
            e_done[m_src] = 1'b1;
            m_phase = 2;
            if (sp) model_emit('0, 1'b1);
            else begin
              m_ol = 1'b1;
              b = exp_q[0]; b[0] = 1'b1; exp_q[0] = b;
            end
          end else if (valid[m_src] && sp) begin
            m_sent++;
            bl = last[m_src] || (m_sent == MAXB);
            e_ready[m_src] = 1'b1;
            model_emit(data[m_src], bl);
            if (bl) begin
              e_done[m_src] = 1'b1;
              m_phase = 2;
            end
          end
        end
        default: if (sp && !gnt[m_src]) m_phase = 0;
      endcase
      chk("ready", 32'(ready), 32'(e_ready));
      chk("done", 32'(done), 32'(e_done));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int g = 0;
    while (m_phase != 0 && g < 50) begin
      tick();
      g++;
    end
    if (m_phase != 0) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle: got phase %0d expected 0 within 50 cycles", m_phase);
    end
  endtask

  task automatic burst(input int s, input int nb, input int drop_at, input int vp, input int rp);
    int sent  = 0;
    int guard = 0;
    bit fin   = 0;
    gnt[s] = 1'b1;
    tick();
    while (!fin && guard < 100) begin
      if (drop_at >= 0 && sent == drop_at) gnt[s] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        valid[k] = ($urandom_range(0, 99) < 40);
        data[k]  = DW'($urandom);
        last[k]  = ($urandom_range(0, 99) < 30);
      end
      valid[s]  = ($urandom_range(0, 99) < vp);
      last[s]   = (sent == nb - 1);
      out_ready = ($urandom_range(0, 99) < rp);
      @(negedge clock);
      if (ready[s]) sent++;
      if (done[s]) fin = 1;
      tick();
      guard++;
    end
    if (!fin) begin
      n_cmp++; n_err++;
      $display("FAIL burst_end: got no done for src %0d expected one within 100 cycles", s);
    end
    valid = '0;
    last  = '0;
    out_ready = 1'b1;
    if (gnt[s]) tick();
    gnt[s] = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; gnt = '0; valid = '0; last = '0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) data[k] = '0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_errs", 32'({err_multi, err_abort}), 32'd0);
    chk("rst_state", 32'(dut_state), 32'(FWD_IDLE));
    tick();

    // 3-beat burst from requester 2, sink always ready
    gnt[2] = 1'b1; tick();
    valid[2] = 1'b1; data[2] = 8'hA1; last[2] = 1'b0;
    @(negedge clock); chk("t1_ready_a1", 32'(ready[2]), 32'd1); tick();
    data[2] = 8'hA2;
    @(negedge clock);
    chk("t1_data_a1", 32'(out_data), 32'hA1);
    chk("t1_src", 32'(out_src), 32'd2);
    chk("t1_last_a1", 32'(out_last), 32'd0);
    tick();
    data[2] = 8'hA3; last[2] = 1'b1;
    @(negedge clock);
    chk("t1_data_a2", 32'(out_data), 32'hA2);
    chk("t1_done_a3", 32'(done[2]), 32'd1);
    tick();
    valid[2] = 1'b0; last[2] = 1'b0;
    @(negedge clock);
    chk("t1_data_a3", 32'(out_data), 32'hA3);
    chk("t1_last_a3", 32'(out_last), 32'd1);
    tick();
    gnt[2] = 1'b0; wait_idle();

    // same burst with a 3-cycle sink stall after A1
    gnt[2] = 1'b1; tick();
    valid[2] = 1'b1; data[2] = 8'hA1;
    @(negedge clock); chk("t2_ready_a1", 32'(ready[2]), 32'd1); tick();
    out_ready = 1'b0; data[2] = 8'hA2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t2_stall_ready", 32'(ready[2]), 32'd0);
      chk("t2_hold_a1", 32'({out_valid, out_data}), 32'h1A1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clock); chk("t2_ready_a2", 32'(ready[2]), 32'd1); tick();
    data[2] = 8'hA3; last[2] = 1'b1;
    @(negedge clock); chk("t2_data_a2", 32'(out_data), 32'hA2); tick();
    valid[2] = 1'b0; last[2] = 1'b0;
    @(negedge clock); chk("t2_data_a3", 32'({out_data, out_last}), 32'h147); tick();
    gnt[2] = 1'b0; wait_idle();

    // timeout: requester 0 never raises last
    gnt[0] = 1'b1; tick();
    valid[0] = 1'b1;
    for (int i = 0; i < MAXB; i++) begin
      data[0] = 8'(8'h10 + i);
      @(negedge clock);
      chk("t3_ready", 32'(ready[0]), 32'd1);
      chk("t3_done", 32'(done[0]), (i == MAXB - 1) ? 32'd1 : 32'd0);
      tick();
    end
    @(negedge clock);
    chk("t3_last_beat", 32'({out_data, out_last}), 32'h27);
    chk("t3_no_more", 32'(ready[0]), 32'd0);
    chk("t3_no_err", 32'(err_abort), 32'd0);
    valid[0] = 1'b0; tick();
    gnt[0] = 1'b0; wait_idle();

    // grant 1 lost after 2 beats
    gnt[1] = 1'b1; tick();
    valid[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data[1] = 8'(8'hB0 + i);
      @(negedge clock); chk("t4_ready", 32'(ready[1]), 32'd1); tick();
    end
    gnt[1] = 1'b0;
    @(negedge clock);
    chk("t4_done", 32'(done[1]), 32'd1);
    chk("t4_ready_off", 32'(ready[1]), 32'd0);
    tick();
    valid[1] = 1'b0;
    @(negedge clock);
    chk("t4_err_abort", 32'(err_abort), 32'd1);
    chk("t4_abort_beat", 32'({out_valid, out_data, out_last}), 32'h201);
    tick();
    wait_idle();
    @(negedge clock); chk("t4_sticky", 32'(err_abort), 32'd1); tick();

    // two grants at once
    gnt = 4'b1001; valid = 4'b1001;
    @(negedge clock); chk("t5_ready", 32'(ready), 32'd0); tick();
    @(negedge clock);
    chk("t5_err_multi", 32'(err_multi), 32'd1);
    chk("t5_state", 32'(dut_state), 32'(FWD_IDLE));
    tick();
    gnt = '0; valid = '0; tick();

    // reset mid-burst with a held beat, then a clean single-beat burst
    do_reset();
    gnt[3] = 1'b1; tick();
    valid[3] = 1'b1; data[3] = 8'hC1; out_ready = 1'b0;
    @(negedge clock); chk("t6_ready", 32'(ready[3]), 32'd1); tick();
    data[3] = 8'hC2;
    @(negedge clock); chk("t6_held", 32'(out_valid), 32'd1); tick();
    reset = 1'b1; tick();
    reset = 1'b0; gnt = '0; valid = '0; out_ready = 1'b1;
    @(negedge clock);
    chk("t6_after_rst", 32'({out_valid, err_multi, err_abort, ready, done}), 32'd0);
    chk("t6_state", 32'(dut_state), 32'(FWD_IDLE));
    tick();
    gnt[1] = 1'b1; tick();
    valid[1] = 1'b1; data[1] = 8'hD1; last[1] = 1'b1;
    @(negedge clock); chk("t6_single_done", 32'({ready[1], done[1]}), 32'd3); tick();
    valid[1] = 1'b0; last[1] = 1'b0;
    @(negedge clock); chk("t6_single_beat", 32'({out_data, out_src, out_last}), 32'h68B); tick();
    gnt[1] = 1'b0; wait_idle();

    // randomized bursts, occasional multi-grant and reset
    for (int it = 0; it < 80; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        gnt = 4'($urandom_range(0, 15));
        if ($countones(gnt) < 2) gnt = 4'b0110;
        valid = 4'($urandom);
        tick(); tick();
        gnt = '0; valid = '0; tick();
      end else if (r == 1) begin
        do_reset();
      end else begin
        int nb, da;
        nb = int'($urandom_range(1, 6));
        da = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
        burst(int'($urandom_range(0, 3)), nb, da, int'($urandom_range(30, 100)),
              int'($urandom_range(30, 100)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
